// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C register target.
//   i2c_slv_state_t : target FSM state encoding (also exported for debug)
//   ACK_LVL/NACK_LVL: SDA line levels for acknowledge / not-acknowledge
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_slv_state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// i2c_reg_slave_if: bus pads plus register port of the I2C register target.
//   scl_i, sda_i : pad inputs (asynchronous to clk)
//   sda_oe       : 1 pulls SDA low; the pad is open-drain with external pullup
//   reg_addr     : current register pointer (AW bits)
//   reg_wdata    : last received data byte
//   reg_wr_en    : write strobe
//   reg_rdata    : read data for reg_addr, combinational on the user side
//   busy         : high from an address match until the next STOP
//
// Register-port handshake: reg_wr_en is a single-cycle "valid" with no
// "ready" -- the user side must always accept it. reg_addr and reg_wdata
// are stable in the strobe cycle. Reads have no handshake: reg_rdata is
// sampled by the target whenever it loads a byte to transmit.
interface i2c_reg_slave_if #(
  parameter int AW = 4
) ();

  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr_en;
  logic [7:0]    reg_rdata;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_wr_en, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_wr_en, busy
  );

endinterface

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: SCL/SDA input conditioning.
//   clk, rst     : system clock, asynchronous active-low reset
//   scl_i, sda_i : raw pad inputs
//   scl_rise     : one-cycle pulse, SCL went 0->1
//   scl_fall     : one-cycle pulse, SCL went 1->0
//   start_det    : one-cycle pulse, SDA 1->0 while SCL high
//   stop_det     : one-cycle pulse, SDA 0->1 while SCL high
//   sda_bit      : SDA sample aligned with the pulses above
// Every output is registered, so a pad edge is seen 3 clk later.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  // Synchronizers and history reset to 1 (idle bus) so leaving reset
  // never fabricates a START or STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_h     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      scl_s1    <= scl_i;
      scl_s2    <= scl_s1;
      scl_h     <= scl_s2;
      sda_s1    <= sda_i;
      sda_s2    <= sda_s1;
      sda_h     <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_h;
      scl_fall  <= ~scl_s2 & scl_h;
      // SCL must be high in both samples, so a START/STOP can never share
      // a cycle with an SCL edge.
      start_det <= scl_s2 & scl_h & sda_h & ~sda_s2;
      stop_det  <= scl_s2 & scl_h & ~sda_h & sda_s2;
      sda_bit   <= sda_s2;
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target with 7-bit address, register pointer byte and
// auto-incrementing register reads/writes. Never clock-stretches.
//   SLAVE_ADDR : 7-bit bus address answered
//   AW         : register pointer width, pointer wraps modulo 2^AW
//   clk        : system clock, >= 16x SCL
//   rst        : asynchronous active-low reset
//   bus        : pads and register port (i2c_reg_slave_if.slave)
//   dbg_state  : current FSM state
import i2c_pkg::*;

module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         AW         = 4
) (
  input  logic           clk,
  input  logic           rst,
  i2c_reg_slave_if.slave bus,
  output i2c_slv_state_t dbg_state
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  i2c_bus_cond u_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_bit   (sda_bit)
  );

  i2c_slv_state_t state;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic [AW-1:0]  ptr;
  logic [7:0]     wdata_q;
  logic           wr_en_q;
  logic           sda_oe_q;
  logic           busy_q;

  // Byte as it stands once the bit sampled on this SCL rise is shifted in.
  logic [7:0] rx_byte;
  assign rx_byte = {shreg[6:0], sda_bit};

  // Receive states shift in on SCL rise; bit_cnt wraps 7->0 on the 8th bit.
  // Transmit uses shreg with the MSB already on the wire: the load stores
  // bits [6:0] left-aligned so shreg[7] is always the next bit to drive.
  // In the *_ACK states sda_oe itself tells the two falls apart: the first
  // fall drives the ACK, the second releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      ptr      <= '0;
      wdata_q  <= 8'h00;
      wr_en_q  <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        bit_cnt  <= 3'd0;
      end else if (start_det) begin
        // Pointer is kept so a repeated START reads from the written pointer.
        state    <= ST_ADDR;
        sda_oe_q <= 1'b0;
        bit_cnt  <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state  <= ST_ADDR_ACK;
                  busy_q <= 1'b1;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (shreg[0]) begin
                // Read: release ACK and put the first MSB on the same fall.
                shreg    <= {bus.reg_rdata[6:0], 1'b0};
                sda_oe_q <= ~bus.reg_rdata[7];
                state    <= ST_RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state    <= ST_PTR;
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= rx_byte[AW-1:0];
                state <= ST_PTR_ACK;
              end
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                wdata_q <= rx_byte;
                wr_en_q <= 1'b1;
                state   <= ST_WDATA_ACK;
              end
            end
          end

          ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                ptr      <= ptr + AW'(1);
                bit_cnt  <= 3'd0;
                state    <= ST_WDATA;
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe_q <= 1'b0;
                state    <= ST_RDATA_ACK;
              end else begin
                sda_oe_q <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          ST_RDATA_ACK: begin
            // Entered on a fall, so the next event is the response rise;
            // a fall seen here always follows an ACK.
            if (scl_rise) begin
              if (sda_bit == ACK_LVL) begin
                ptr <= ptr + AW'(1);
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else if (scl_fall) begin
              shreg    <= {bus.reg_rdata[6:0], 1'b0};
              sda_oe_q <= ~bus.reg_rdata[7];
              bit_cnt  <= 3'd0;
              state    <= ST_RDATA;
            end
          end

          ST_WAIT_STOP: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            state    <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = ptr;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr_en = wr_en_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;

endmodule
